pipe_hazard_ctrl: RTL and testbench

//   Pipeline sequencer for the decode->execute stage register of the 16-bit core.

---
 rtl/pipe_pkg.sv | 29 ++
 rtl/div_cycle_counter.sv | 44 ++++
 rtl/pipe_hazard_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the decode->execute hazard sequencer.
//   state_e     : sequencer FSM encoding (StRun=0, StDiv=1)
//   ctrl_t      : bundle of the pipeline control outputs
//   CtrlNop     : all-zero control bundle (no stall, no bubble, no flush)
//   RegWDefault : default register-index width
//   CntW        : divide down-counter width (covers DIV_CYCLES up to 255)
package pipe_pkg;

    typedef enum logic {
        StRun = 1'b0,
        StDiv = 1'b1
    } state_e;

    typedef struct packed {
        logic stall_fd;
        logic stall_de;
        logic bubble_de;
        logic bubble_em;
        logic flush_fd;
        logic div_start;
        logic div_busy;
    } ctrl_t;

    localparam ctrl_t CtrlNop = '0;

    localparam int unsigned RegWDefault = 8;
    localparam int unsigned CntW        = 8;

endpackage

// File: rtl/div_cycle_counter.sv
// Loadable down-counter with a zero flag, used to time divide occupancy of EX.
// Ports:
//   clk      in   core clock, rising edge
//   rst      in   synchronous active-high reset, clears the count
//   load     in   load load_val this cycle (wins over dec)
//   load_val in   value to load
//   dec      in   decrement by one (holds at zero)
//   zero     out  count is zero
module div_cycle_counter
    import pipe_pkg::*;
#(
    parameter int unsigned W = CntW
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall / bubble / flush sequencer for the Dec->Ex stage register.
// Handles load-use hazards, multi-cycle divide occupancy of EX and taken
// jumps/branches resolved in EX. All control outputs are combinational from
// the current inputs and FSM state, and are forced to zero while rst is high.
// Optional build macro: HAZ_PERF_CNT_EN adds stall-cycle and divide counters;
// without it perf_stalls/perf_divs are tied to zero.
// Ports:
//   clk, rst                     clock and synchronous active-high reset
//   dec_a_reg/dec_b_reg          source indices of the decode instruction
//   dec_use_a/dec_use_b          decode instruction reads A / B
//   ex_mem, ex_store, ex_rwe     EX memory op / store / register write
//   ex_c_reg                     EX destination index
//   ex_div, ex_br_taken          EX divide / taken jump or branch
//   stall_fd, stall_de           hold fetch/decode, hold Dec->Ex
//   bubble_de, bubble_em         load NOP controls into Dec->Ex / Ex->Mem
//   flush_fd                     kill the fetch/decode instruction
//   div_start, div_busy          divider start pulse / divider running
//   perf_stalls, perf_divs       performance counters
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned DIV_CYCLES = 4,
    parameter int unsigned REG_W      = RegWDefault
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] dec_a_reg,
    input  logic [REG_W-1:0] dec_b_reg,
    input  logic             dec_use_a,
    input  logic             dec_use_b,
    input  logic             ex_mem,
    input  logic             ex_store,
    input  logic             ex_rwe,
    input  logic [REG_W-1:0] ex_c_reg,
    input  logic             ex_div,
    input  logic             ex_br_taken,
    output logic             stall_fd,
    output logic             stall_de,
    output logic             bubble_de,
    output logic             bubble_em,
    output logic             flush_fd,
    output logic             div_start,
    output logic             div_busy,
    output logic [15:0]      perf_stalls,
    output logic [15:0]      perf_divs
);

    localparam bit          MultiCycle = (DIV_CYCLES > 1);
    // The start cycle and the release cycle are not counted, hence the -2.
    localparam int unsigned LoadInt    = (DIV_CYCLES > 1) ? DIV_CYCLES - 2 : 0;
    localparam logic [CntW-1:0] CntLoad = LoadInt[CntW-1:0];

    state_e state_q;
    state_e state_d;
    ctrl_t  ctrl;
    logic   lu;
    logic   cnt_load;
    logic   cnt_dec;
    logic   cnt_zero;

    assign lu = ex_mem & ~ex_store & ex_rwe &
                ((dec_use_a & (dec_a_reg == ex_c_reg)) |
                 (dec_use_b & (dec_b_reg == ex_c_reg)));

    div_cycle_counter #(
        .W (CntW)
    ) u_div_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (CntLoad),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and counter control
    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        unique case (state_q)
            StRun: begin
                if (!ex_br_taken && ex_div && MultiCycle) begin
                    state_d  = StDiv;
                    cnt_load = 1'b1;
                end
            end
            StDiv: begin
                // Release coincides with the Dec->Ex register advancing, so the
                // same divide is never seen again in StRun.
                if (cnt_zero) begin
                    state_d = StRun;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: state_d = StRun;
        endcase
    end

    // Outputs
    always_comb begin
        ctrl = CtrlNop;
        if (!rst) begin
            unique case (state_q)
                StRun: begin
                    if (ex_br_taken) begin
                        ctrl.flush_fd  = 1'b1;
                        ctrl.bubble_de = 1'b1;
                    end else if (ex_div) begin
                        ctrl.div_start = 1'b1;
                        ctrl.div_busy  = 1'b1;
                        if (MultiCycle) begin
                            ctrl.stall_fd  = 1'b1;
                            ctrl.stall_de  = 1'b1;
                            ctrl.bubble_em = 1'b1;
                        end
                    end else if (lu) begin
                        // The load advances; the consumer waits one cycle in decode.
                        ctrl.stall_fd  = 1'b1;
                        ctrl.bubble_de = 1'b1;
                    end
                end
                StDiv: begin
                    ctrl.div_busy = 1'b1;
                    if (!cnt_zero) begin
                        ctrl.stall_fd  = 1'b1;
                        ctrl.stall_de  = 1'b1;
                        ctrl.bubble_em = 1'b1;
                    end
                end
                default: ctrl = CtrlNop;
            endcase
        end
    end

    assign stall_fd  = ctrl.stall_fd;
    assign stall_de  = ctrl.stall_de;
    assign bubble_de = ctrl.bubble_de;
    assign bubble_em = ctrl.bubble_em;
    assign flush_fd  = ctrl.flush_fd;
    assign div_start = ctrl.div_start;
    assign div_busy  = ctrl.div_busy;

`ifdef HAZ_PERF_CNT_EN
    logic [15:0] perf_stalls_q;
    logic [15:0] perf_stalls_d;
    logic [15:0] perf_divs_q;
    logic [15:0] perf_divs_d;

    always_comb begin
        perf_stalls_d = perf_stalls_q;
        perf_divs_d   = perf_divs_q;
        if (ctrl.stall_fd && (perf_stalls_q != 16'hFFFF)) begin
            perf_stalls_d = perf_stalls_q + 16'd1;
        end
        if (ctrl.div_start) begin
            perf_divs_d = perf_divs_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stalls_q <= '0;
            perf_divs_q   <= '0;
        end else begin
            perf_stalls_q <= perf_stalls_d;
            perf_divs_q   <= perf_divs_d;
        end
    end

    assign perf_stalls = perf_stalls_q;
    assign perf_divs   = perf_divs_q;
`else
    assign perf_stalls = 16'h0000;
    assign perf_divs   = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl (DIV_CYCLES=4). A cycle-level model tracks how
// long the current divide has sat in EX and derives every output from the
// behavioural rules; directed literal checks pin the model's key cycles.
module tb_pipe_hazard_ctrl;

    localparam int unsigned DivCycles = 4;

    logic       clk;
    logic       rst;
    logic [7:0] dec_a_reg;
    logic [7:0] dec_b_reg;
    logic       dec_use_a;
    logic       dec_use_b;
    logic       ex_mem;
    logic       ex_store;
    logic       ex_rwe;
    logic [7:0] ex_c_reg;
    logic       ex_div;
    logic       ex_br_taken;
    logic       stall_fd;
    logic       stall_de;
    logic       bubble_de;
    logic       bubble_em;
    logic       flush_fd;
    logic       div_start;
    logic       div_busy;
    logic [15:0] perf_stalls;
    logic [15:0] perf_divs;

    pipe_hazard_ctrl #(
        .DIV_CYCLES (DivCycles),
        .REG_W      (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .dec_a_reg   (dec_a_reg),
        .dec_b_reg   (dec_b_reg),
        .dec_use_a   (dec_use_a),
        .dec_use_b   (dec_use_b),
        .ex_mem      (ex_mem),
        .ex_store    (ex_store),
        .ex_rwe      (ex_rwe),
        .ex_c_reg    (ex_c_reg),
        .ex_div      (ex_div),
        .ex_br_taken (ex_br_taken),
        .stall_fd    (stall_fd),
        .stall_de    (stall_de),
        .bubble_de   (bubble_de),
        .bubble_em   (bubble_em),
        .flush_fd    (flush_fd),
        .div_start   (div_start),
        .div_busy    (div_busy),
        .perf_stalls (perf_stalls),
        .perf_divs   (perf_divs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model state: cycles the current divide has already spent in EX (0 = none).
    int age    = 0;
    int m_stls = 0;
    int m_divs = 0;

    logic e_sfd, e_sde, e_bde, e_bem, e_ffd, e_dst, e_dby;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_eval();
        logic lu;
        lu = ex_mem & ~ex_store & ex_rwe &
             ((dec_use_a & (dec_a_reg == ex_c_reg)) | (dec_use_b & (dec_b_reg == ex_c_reg)));
        {e_sfd, e_sde, e_bde, e_bem, e_ffd, e_dst, e_dby} = '0;
        if (rst) begin
            // all zero
        end else if (age > 0) begin
            e_dby = 1'b1;
            // Divide spends DivCycles cycles in EX; every cycle but the last stalls.
            if (age < DivCycles - 1) {e_sfd, e_sde, e_bem} = 3'b111;
        end else if (ex_br_taken) begin
            e_ffd = 1'b1;
            e_bde = 1'b1;
        end else if (ex_div) begin
            e_dst = 1'b1;
            e_dby = 1'b1;
            if (DivCycles > 1) {e_sfd, e_sde, e_bem} = 3'b111;
        end else if (lu) begin
            e_sfd = 1'b1;
            e_bde = 1'b1;
        end
    endtask

    task automatic model_step();
        if (rst) begin
            age    = 0;
            m_stls = 0;
            m_divs = 0;
        end else begin
            if (e_sfd && m_stls < 16'hFFFF) m_stls++;
            if (e_dst) m_divs = (m_divs + 1) % 65536;
            if (age > 0) age = (age + 1 == DivCycles) ? 0 : age + 1;
            else if (e_dst && DivCycles > 1) age = 1;
        end
    endtask

    // One clock: compare everything on the falling edge, advance the model on
    // the rising edge, then leave 1 time unit for the caller to drive inputs.
    task automatic tick();
        @(negedge clk);
        model_eval();
        check("stall_fd", 16'(stall_fd), 16'(e_sfd));
        check("stall_de", 16'(stall_de), 16'(e_sde));
        check("bubble_de", 16'(bubble_de), 16'(e_bde));
        check("bubble_em", 16'(bubble_em), 16'(e_bem));
        check("flush_fd", 16'(flush_fd), 16'(e_ffd));
        check("div_start", 16'(div_start), 16'(e_dst));
        check("div_busy", 16'(div_busy), 16'(e_dby));
`ifdef HAZ_PERF_CNT_EN
        check("perf_stalls", perf_stalls, 16'(m_stls));
        check("perf_divs", perf_divs, 16'(m_divs));
`else
        check("perf_stalls", perf_stalls, 16'h0000);
        check("perf_divs", perf_divs, 16'h0000);
`endif
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        dec_a_reg = 8'h00; dec_b_reg = 8'h00; dec_use_a = 1'b0; dec_use_b = 1'b0;
        ex_mem = 1'b0; ex_store = 1'b0; ex_rwe = 1'b0; ex_c_reg = 8'h00;
        ex_div = 1'b0; ex_br_taken = 1'b0;
    endtask

    typedef struct {
        logic mem, store, rwe, use_a, use_b;
        logic [7:0] a, b, c;
        logic exp;
    } lu_vec_t;

    lu_vec_t lu_tab[8];

    initial begin
        lu_tab[0] = '{1, 0, 1, 1, 0, 8'h05, 8'h00, 8'h05, 1};
        lu_tab[1] = '{1, 0, 1, 0, 0, 8'h05, 8'h05, 8'h05, 0};
        lu_tab[2] = '{1, 1, 1, 1, 1, 8'h05, 8'h05, 8'h05, 0};
        lu_tab[3] = '{1, 0, 0, 1, 0, 8'h05, 8'h00, 8'h05, 0};
        lu_tab[4] = '{1, 0, 1, 0, 1, 8'h03, 8'h07, 8'h07, 1};
        lu_tab[5] = '{0, 0, 1, 1, 1, 8'h07, 8'h07, 8'h07, 0};
        lu_tab[6] = '{1, 0, 1, 1, 1, 8'h00, 8'h09, 8'h00, 1};
        lu_tab[7] = '{1, 0, 1, 1, 1, 8'h01, 8'h02, 8'h03, 0};

        idle_inputs();
        rst = 1'b1;
        ex_div = 1'b1;
        #1;

        // Reset held two cycles with a divide in EX: everything quiet.
        for (int i = 0; i < 2; i++) begin
            check("rst_stall_fd", 16'(stall_fd), 16'h0);
            check("rst_div_start", 16'(div_start), 16'h0);
            tick();
        end

        // Release: divide starts at t, stalls t..t+2, busy through t+3.
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("div_lit_start", 16'(div_start), 16'(k == 0));
            check("div_lit_stall_fd", 16'(stall_fd), 16'(k < 3));
            check("div_lit_stall_de", 16'(stall_de), 16'(k < 3));
            check("div_lit_bubble_em", 16'(bubble_em), 16'(k < 3));
            check("div_lit_busy", 16'(div_busy), 16'h1);
            tick();
        end
        ex_div = 1'b0;
        tick();

        // Load-use vectors.
        for (int i = 0; i < 8; i++) begin
            idle_inputs();
            ex_mem = lu_tab[i].mem; ex_store = lu_tab[i].store; ex_rwe = lu_tab[i].rwe;
            dec_use_a = lu_tab[i].use_a; dec_use_b = lu_tab[i].use_b;
            dec_a_reg = lu_tab[i].a; dec_b_reg = lu_tab[i].b; ex_c_reg = lu_tab[i].c;
            #1;
            check("lu_lit_stall_fd", 16'(stall_fd), 16'(lu_tab[i].exp));
            check("lu_lit_bubble_de", 16'(bubble_de), 16'(lu_tab[i].exp));
            check("lu_lit_stall_de", 16'(stall_de), 16'h0);
            tick();
        end

        // Branch together with a load-use and a divide: branch wins.
        idle_inputs();
        ex_mem = 1'b1; ex_rwe = 1'b1; ex_c_reg = 8'h05; dec_a_reg = 8'h05; dec_use_a = 1'b1;
        ex_br_taken = 1'b1;
        #1;
        check("br_lit_flush_fd", 16'(flush_fd), 16'h1);
        check("br_lit_bubble_de", 16'(bubble_de), 16'h1);
        check("br_lit_stall_fd", 16'(stall_fd), 16'h0);
        tick();
        ex_div = 1'b1;
        tick();
        idle_inputs();
        tick();

        // Back-to-back divides: second starts right after the first releases.
        ex_div = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            check("b2b_lit_start", 16'(div_start), 16'(k == 0 || k == 4));
            tick();
        end
        idle_inputs();
        tick();

        // Reset in the middle of a divide, divide still present afterwards.
        ex_div = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("mid_rst_lit_busy", 16'(div_busy), 16'h0);
        tick();
        tick();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("rediv_lit_start", 16'(div_start), 16'(k == 0));
            check("rediv_lit_stall", 16'(stall_fd), 16'(k < 3));
            tick();
        end
        idle_inputs();
        tick();

        // Counter scenario: two divides and one load-use after a clean reset.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            ex_div = 1'b1;
            for (int k = 0; k < 4; k++) tick();
            ex_div = 1'b0;
            tick();
        end
        ex_mem = 1'b1; ex_rwe = 1'b1; ex_c_reg = 8'h05; dec_a_reg = 8'h05; dec_use_a = 1'b1;
        tick();
        idle_inputs();
        #1;
`ifdef HAZ_PERF_CNT_EN
        check("perf_lit_divs", perf_divs, 16'd2);
        check("perf_lit_stalls", perf_stalls, 16'd7);
`else
        check("perf_lit_divs", perf_divs, 16'd0);
        check("perf_lit_stalls", perf_stalls, 16'd0);
`endif
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
